pong_match_ctrl: RTL



---
 rtl/pong_match_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Match-level controller for two-player Pong: serve countdown, play/pause,
// scoring with optional win-by-two, ball gating and re-centre pulses.
module pong_match_ctrl #(
   parameter int WIN_SCORE    = 5,
   parameter int WIN_BY_TWO   = 0,
   parameter int SERVE_FRAMES = 60,
   parameter int SCORE_W      = $clog2(WIN_SCORE + 2)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               refresh_tick,
   input  logic               start,
   input  logic               pause,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic [2:0]         state,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               ball_en,
   output logic               ball_rst,
   output logic               serve_dir,
   output logic               point_pulse,
   output logic               game_over,
   output logic               winner
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SERVE  = 3'd1,
      ST_PLAY   = 3'd2,
      ST_PAUSED = 3'd3,
      ST_POINT  = 3'd4,
      ST_OVER   = 3'd5
   } state_t;

   localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'((SERVE_FRAMES > 0) ? SERVE_FRAMES - 1 : 0);
   localparam logic [SCORE_W-1:0] PT_ONE    = SCORE_W'(1);
   localparam logic [SCORE_W-1:0] WIN_PTS   = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] DEUCE_PTS = SCORE_W'(WIN_SCORE - 1);
   localparam logic [SCORE_W:0]   LEAD_PTS  = (SCORE_W + 1)'(2);

   state_t             state_r;
   logic [SCORE_W-1:0] score1_r, score2_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               ball_en_r, ball_rst_r, serve_dir_r, point_pulse_r, game_over_r, winner_r;
   logic               start_q_r, pause_q_r, start_rise_r, pause_rise_r;
   logic [SCORE_W-1:0] scorer_s, other_s;
   logic               win_s, deuce_s;

   // Win and deuce evaluation; serve_dir already points at the conceding side
   always_comb begin
      if (serve_dir_r) begin
         scorer_s = score1_r;
         other_s  = score2_r;
      end else begin
         scorer_s = score2_r;
         other_s  = score1_r;
      end
      if (WIN_BY_TWO != 0) begin
         win_s = (scorer_s >= WIN_PTS) && ({1'b0, scorer_s} >= ({1'b0, other_s} + LEAD_PTS));
      end else begin
         win_s = (scorer_s == WIN_PTS);
      end
      deuce_s = (WIN_BY_TWO != 0) && (score1_r == score2_r) && (score1_r >= DEUCE_PTS);
   end

   // Button edge detection and the match state machine with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         score1_r      <= '0;
         score2_r      <= '0;
         cnt_r         <= '0;
         ball_en_r     <= 1'b0;
         ball_rst_r    <= 1'b0;
         serve_dir_r   <= 1'b0;
         point_pulse_r <= 1'b0;
         game_over_r   <= 1'b0;
         winner_r      <= 1'b0;
         start_q_r     <= 1'b1;
         pause_q_r     <= 1'b1;
         start_rise_r  <= 1'b0;
         pause_rise_r  <= 1'b0;
      end else begin
         start_q_r     <= start;
         pause_q_r     <= pause;
         start_rise_r  <= start & ~start_q_r;
         pause_rise_r  <= pause & ~pause_q_r;
         ball_rst_r    <= 1'b0;
         point_pulse_r <= 1'b0;
         ball_en_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_rise_r) begin
                  state_r    <= ST_SERVE;
                  score1_r   <= '0;
                  score2_r   <= '0;
                  cnt_r      <= '0;
                  ball_rst_r <= 1'b1;
               end
            end
            ST_SERVE: begin
               if (SERVE_FRAMES == 0) begin
                  state_r   <= ST_PLAY;
                  ball_en_r <= 1'b1;
               end else if (refresh_tick) begin
                  if (cnt_r == CNT_LAST) begin
                     state_r   <= ST_PLAY;
                     ball_en_r <= 1'b1;
                     cnt_r     <= '0;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            ST_PLAY: begin
               if (miss_left && miss_right) begin
                  state_r     <= ST_SERVE;
                  serve_dir_r <= ~serve_dir_r;
                  ball_rst_r  <= 1'b1;
                  cnt_r       <= '0;
               end else if (miss_left) begin
                  state_r       <= ST_POINT;
                  score2_r      <= score2_r + PT_ONE;
                  serve_dir_r   <= 1'b0;
                  point_pulse_r <= 1'b1;
               end else if (miss_right) begin
                  state_r       <= ST_POINT;
                  score1_r      <= score1_r + PT_ONE;
                  serve_dir_r   <= 1'b1;
                  point_pulse_r <= 1'b1;
               end else if (pause_rise_r) begin
                  state_r <= ST_PAUSED;
               end else begin
                  ball_en_r <= 1'b1;
               end
            end
            ST_PAUSED: begin
               if (pause_rise_r) begin
                  state_r   <= ST_PLAY;
                  ball_en_r <= 1'b1;
               end
            end
            ST_POINT: begin
               if (win_s) begin
                  state_r     <= ST_OVER;
                  game_over_r <= 1'b1;
                  winner_r    <= ~serve_dir_r;
               end else begin
                  // Equal scores at or past match point fall back to one below the target
                  if (deuce_s) begin
                     score1_r <= DEUCE_PTS;
                     score2_r <= DEUCE_PTS;
                  end
                  state_r    <= ST_SERVE;
                  ball_rst_r <= 1'b1;
                  cnt_r      <= '0;
               end
            end
            ST_OVER: begin
               if (start_rise_r) begin
                  state_r     <= ST_SERVE;
                  score1_r    <= '0;
                  score2_r    <= '0;
                  cnt_r       <= '0;
                  game_over_r <= 1'b0;
                  ball_rst_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign state       = state_r;
   assign score1      = score1_r;
   assign score2      = score2_r;
   assign ball_en     = ball_en_r;
   assign ball_rst    = ball_rst_r;
   assign serve_dir   = serve_dir_r;
   assign point_pulse = point_pulse_r;
   assign game_over   = game_over_r;
   assign winner      = winner_r;

endmodule
